serial_adder_ctrl: RTL and testbench



---
 rtl/serial_adder_ctrl_pkg.sv | 14 +
 rtl/serial_adder_ctrl_fulladder.sv | 13 +
 rtl/serial_adder_ctrl.sv | 96 +++++++++
 tb/tb_serial_adder_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_ctrl_pkg.sv
// Shared constants for the bit-serial adder sequencer: FSM state codes and
// the bit-counter width derivation.
package serial_adder_ctrl_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Counter must stay at least one bit wide so WIDTH = 1 still elaborates.
    function automatic int cnt_width(input int width);
        return (width <= 1) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_adder_ctrl_fulladder.sv
// Single-bit full adder; the only arithmetic element of the serial datapath.
module serial_adder_ctrl_fulladder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder sequencer: one full adder reused over WIDTH clocks, LSB first,
// with a start/done handshake and registered, held results.
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    input  logic             inCarry,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic [1:0]       state
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    // Handshake: start is a level request honoured only in IDLE; the operands
    // are captured on that edge. done is a single-cycle pulse and sum/carry
    // stay valid from that pulse until the next completion or reset.

    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic [CNT_W-1:0] count;
    logic             cflop;
    logic             fa_sum;
    logic             fa_carry;

    serial_adder_ctrl_fulladder fa (
        .a    (opa[0]),
        .b    (opb[0]),
        .cin  (cflop),
        .sum  (fa_sum),
        .cout (fa_carry)
    );

    // New bit enters at the MSB so after WIDTH shifts the LSB sits at bit 0.
    generate
        if (WIDTH == 1) begin : g_acc_w1
            assign acc_next = fa_sum;
        end else begin : g_acc_wn
            assign acc_next = {fa_sum, acc[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
            opa   <= '0;
            opb   <= '0;
            acc   <= '0;
            cflop <= 1'b0;
            count <= '0;
            sum   <= '0;
            carry <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        opa   <= inA;
                        opb   <= inB;
                        cflop <= inCarry;
                        count <= '0;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    acc   <= acc_next;
                    opa   <= opa >> 1;
                    opb   <= opb >> 1;
                    cflop <= fa_carry;
                    count <= count + CNT_W'(1);
                    if (count == LAST) begin
                        sum   <= acc_next;
                        carry <= fa_carry;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: directed cases plus randomized
// traffic against a cycle-level arithmetic reference model with an expected queue.
module tb_serial_adder_ctrl;

    localparam int W = 8;

    logic         clock = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_c;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         carry;
    logic [1:0]   state;

    logic start1, a1, b1, c1;
    logic busy1, done1, sum1, carry1;
    logic [1:0] state1;

    int n_checks = 0;
    int n_errors = 0;

    logic [W:0] exp_q[$];
    logic [W:0] m_res;
    int         phase;

    always #5 clock = ~clock;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clock(clock), .reset(reset), .start(start), .inA(in_a), .inB(in_b),
        .inCarry(in_c), .busy(busy), .done(done), .sum(sum), .carry(carry),
        .state(state)
    );

    serial_adder_ctrl #(.WIDTH(1)) dut1 (
        .clock(clock), .reset(reset), .start(start1), .inA(a1), .inB(b1),
        .inCarry(c1), .busy(busy1), .done(done1), .sum(sum1), .carry(carry1),
        .state(state1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: phase 0 = idle, 1..W = running, W+1 = done cycle.
    always @(posedge clock) begin
        logic [W:0] full;
        if (reset) begin
            phase = 0;
            m_res = '0;
            exp_q.delete();
        end else if (phase == 0) begin
            if (start) begin
                full = {1'b0, in_a} + {1'b0, in_b} + {{W{1'b0}}, in_c};
                exp_q.push_back(full);
                phase = 1;
            end
        end else if (phase == W + 1) begin
            phase = 0;
        end else begin
            phase = phase + 1;
            if (phase == W + 1) begin
                if (exp_q.size() == 0) begin
                    check("queue_underflow", 32'd1, 32'd0);
                end else begin
                    m_res = exp_q.pop_front();
                end
            end
        end
        #1;
        check("busy", {31'd0, busy}, {31'd0, (phase >= 1 && phase <= W)});
        check("done", {31'd0, done}, {31'd0, (phase == W + 1)});
        check("state", {30'd0, state}, (phase == 0) ? 32'd0 : (phase == W + 1) ? 32'd2 : 32'd1);
        check("result", {23'd0, carry, sum}, {23'd0, m_res});
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < 40) begin
            tick();
            lat++;
        end
        if (!done) check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                           input logic [W-1:0] es, input logic ec);
        int lat;
        in_a = a; in_b = b; in_c = c; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(lat);
        check("latency", lat, W);
        check("sum", {24'd0, sum}, {24'd0, es});
        check("carry", {31'd0, carry}, {31'd0, ec});
        tick();
    endtask

    initial begin
        int lat;
        reset = 1'b1; start = 1'b0; in_a = '0; in_b = '0; in_c = 1'b0;
        start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();

        // WIDTH = 1 build
        a1 = 1'b1; b1 = 1'b1; c1 = 1'b1; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        check("w1_busy", {31'd0, busy1}, 32'd1);
        tick();
        check("w1_done", {31'd0, done1}, 32'd1);
        check("w1_sum", {31'd0, sum1}, 32'd1);
        check("w1_carry", {31'd0, carry1}, 32'd1);
        tick();
        check("w1_idle", {31'd0, done1 | busy1}, 32'd0);

        run_add(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);
        run_add(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        run_add(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);

        // start pulsed during RUN must be ignored
        in_a = 8'h10; in_b = 8'h20; in_c = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        in_a = 8'h01; in_b = 8'h01; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(lat);
        check("ign_sum", {24'd0, sum}, 32'h30);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("ign_hold", {24'd0, sum}, 32'h30);
        end

        // reset in cycle 5 of RUN aborts without done
        in_a = 8'h7F; in_b = 8'h01; in_c = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_sum", {24'd0, sum}, 32'd0);
        check("rst_state", {30'd0, state}, 32'd0);
        run_add(8'h02, 8'h03, 1'b0, 8'h05, 1'b0);

        // back-to-back with start held high and operands changing every cycle
        start = 1'b1;
        for (int i = 0; i < 60; i++) begin
            in_a = W'($urandom); in_b = W'($urandom); in_c = 1'($urandom);
            tick();
        end
        start = 1'b0;
        for (int i = 0; i < 12; i++) tick();

        // random traffic with gaps, operand scrambling and stray starts
        for (int n = 0; n < 25; n++) begin
            int gap;
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) tick();
            in_a = W'($urandom); in_b = W'($urandom); in_c = 1'($urandom);
            start = 1'b1;
            tick();
            lat = 0;
            while (!done && lat < 40) begin
                in_a = W'($urandom); in_b = W'($urandom); in_c = 1'($urandom);
                start = 1'($urandom_range(0, 1));
                tick();
                lat++;
            end
            start = 1'b0;
            check("rnd_latency", lat, W);
            tick();
        end

        for (int i = 0; i < 12; i++) tick();
        check("queue_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
